// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: primed elastic stereo PCM buffer feeding the HDMI encoder audio inputs.
// Define AUDIO_FIFO_HOLD_EN to hold the last played sample instead of muting to zero.
module audio_sample_fifo #(
  parameter int DEPTH_LOG2  = 3,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [15:0]           in_l,
  input  logic [15:0]           in_r,
  input  logic                  sample_req,
  output logic [15:0]           out_l,
  output logic [15:0]           out_r,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  playing,
  output logic                  underrun,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {PRIME, RUN} state_t;
  state_t state, state_next;
  logic [31:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic empty, full, pop, starve, wr_acc, drop;
  logic [15:0] mute_l, mute_r;
`ifdef AUDIO_FIFO_HOLD_EN
  // outputs only ever take popped values or the mute value, so they already hold the last pop
  assign mute_l = out_l;
  assign mute_r = out_r;
`else
  assign mute_l = '0;
  assign mute_r = '0;
`endif
  assign playing = state == RUN;
  always_comb begin
    empty = level == '0;
    full = level == (DEPTH_LOG2+1)'(DEPTH);
    pop = sample_req && state == RUN && !empty;
    starve = sample_req && state == RUN && empty;
    wr_acc = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
    state_next = state == PRIME ? (level >= (DEPTH_LOG2+1)'(PRIME_LEVEL) ? RUN : PRIME)
                                : (starve ? PRIME : RUN);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= PRIME;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      out_l <= '0;
      out_r <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      wr_ptr <= wr_acc ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      level <= level + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(pop);
      if (sample_req) {out_l, out_r} <= pop ? mem[rd_ptr] : {mute_l, mute_r};
      underrun <= starve;
      overflow <= drop;
    end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= {in_l, in_r};
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: scoreboard bench with a queue-based reference model of the audio FIFO.
module tb_audio_sample_fifo;
  localparam int DL = 3, DEPTH = 8, PL = 4;
`ifdef AUDIO_FIFO_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, sample_req = 1'b0;
  logic [15:0] in_l = '0, in_r = '0, out_l, out_r;
  logic [DL:0] level;
  logic playing, underrun, overflow;
  audio_sample_fifo #(.DEPTH_LOG2(DL), .PRIME_LEVEL(PL)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_l(in_l), .in_r(in_r),
    .sample_req(sample_req), .out_l(out_l), .out_r(out_r), .level(level),
    .playing(playing), .underrun(underrun), .overflow(overflow));
  always #5 clk = ~clk;
  typedef struct {logic [15:0] l, r; int lvl; bit play, und, ovf;} exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  logic [31:0] mq[$];
  bit m_play = 1'b0;
  logic [15:0] m_l = '0, m_r = '0, last_l = '0, last_r = '0;
  task automatic model_reset();
    mq.delete();
    m_play = 1'b0;
    m_l = '0; m_r = '0; last_l = '0; last_r = '0;
  endtask
  task automatic cyc(input bit iv, input logic [15:0] l, input logic [15:0] r, input bit req);
    int lvl;
    bit pop, und, ovf;
    logic [31:0] v;
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_l = l; in_r = r; sample_req = req;
    lvl = mq.size();
    pop = req && m_play && lvl > 0;
    und = req && m_play && lvl == 0;
    ovf = iv && lvl == DEPTH && !pop;
    if (pop) begin
      v = mq.pop_front();
      m_l = v[31:16]; m_r = v[15:0];
      last_l = m_l; last_r = m_r;
    end else if (req) begin
      m_l = HOLD ? last_l : 16'h0;
      m_r = HOLD ? last_r : 16'h0;
    end
    if (iv && !ovf) mq.push_back({l, r});
    m_play = m_play ? !und : lvl >= PL;
    e.l = m_l; e.r = m_r; e.lvl = mq.size(); e.play = m_play; e.und = und; e.ovf = ovf;
    sb.push_back(e);
  endtask
  task automatic wr(input logic [15:0] v);
    cyc(1'b1, v, v, 1'b0);
  endtask
  task automatic rq();
    cyc(1'b0, 16'h0, 16'h0, 1'b1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; sample_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_l !== 16'h0 || out_r !== 16'h0 || level !== '0 || playing !== 1'b0 ||
        underrun !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out_l=%h out_r=%h level=%0d playing=%b underrun=%b overflow=%b, required all zero",
               out_l, out_r, level, playing, underrun, overflow);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (out_l !== e.l || out_r !== e.r || int'(level) != e.lvl || playing !== e.play ||
          underrun !== e.und || overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL cycle @%0t: got l=%h r=%h lvl=%0d play=%b und=%b ovf=%b, expected l=%h r=%h lvl=%0d play=%b und=%b ovf=%b",
                 $time, out_l, out_r, level, playing, underrun, overflow,
                 e.l, e.r, e.lvl, e.play, e.und, e.ovf);
      end
    end
  end
  initial begin
    do_reset();
    for (int i = 1; i <= 3; i++) wr(16'(i * 16'h0101));
    rq();
    idle(1);
    wr(16'h0404);
    idle(2);
    do_reset();
    for (int i = 1; i <= 8; i++) wr(16'(i * 16'h1111));
    idle(2);
    for (int i = 0; i < 8; i++) begin
      rq();
      idle(1);
    end
    for (int i = 0; i < 8; i++) wr(16'(16'hA000 + i));
    wr(16'hDEAD);
    idle(1);
    cyc(1'b1, 16'h9999, 16'h9999, 1'b1);
    for (int i = 0; i < 8; i++) rq();
    rq();
    idle(1);
    for (int i = 0; i < 4; i++) wr(16'(16'hB000 + i));
    idle(2);
    for (int i = 0; i < 4; i++) rq();
    cyc(1'b1, 16'hC0DE, 16'h1234, 1'b1);
    idle(1);
    do_reset();
    for (int i = 0; i < 5; i++) wr(16'(16'h5000 + i));
    idle(1);
    do_reset();
    rq();
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 99) < 50, 16'($urandom), 16'($urandom), $urandom_range(0, 99) < 45);
    idle(2);
    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
